// File: rtl/serv_bus_sched.sv
// serv_bus_sched
//   Shares one memory bus between a SERV-style core (instruction fetch and
//   data ports) and an external debug/DMA master. Ownership is granted from
//   IDLE, held until the owner is acked or drops its cycle, then returned to
//   IDLE for at least one cycle. When the core and the external master both
//   request, ownership strictly alternates. An optional watchdog aborts a
//   transfer that the memory never acks. It completes the transfer with
//   zero read data and pulses o_timeout on the following cycle.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_ibus_*  / o_ibus_*  core fetch request (read only) and its response
//   i_dbus_*  / o_dbus_*  core data request and its response
//   i_ext_*   / o_ext_*   external master request and its response
//   o_wb_*    / i_wb_*    shared memory bus
//   o_timeout             one-cycle pulse after a watchdog abort
//
// Parameter
//   TIMEOUT_W             watchdog counter width; 0 disables the watchdog
module serv_bus_sched #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // core instruction fetch
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  // core data access
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  // external master
  input  logic [31:0] i_ext_adr,
  input  logic [31:0] i_ext_dat,
  input  logic [3:0]  i_ext_sel,
  input  logic        i_ext_we,
  input  logic        i_ext_cyc,
  output logic [31:0] o_ext_rdt,
  output logic        o_ext_ack,
  // shared memory bus
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  // watchdog
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    EXT  = 2'd2
  } state_t;

  // A zero-width watchdog is not expressible, so keep one dummy counter bit
  // and disable it through WDOG_EN.
  localparam int            CW      = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam bit            WDOG_EN = (TIMEOUT_W > 0);
  // The counter holds the number of completed owned cycles without an ack.
  // The current cycle is the last one allowed when the count is one short
  // of 2^TIMEOUT_W-1.
  localparam logic [CW-1:0] EXP_CNT = {CW{1'b1}} - CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_ext;
  logic          r_timeout;
  logic [CW-1:0] r_cnt;

  logic          w_core_req;
  logic          w_owner_cyc;
  logic          w_sel_dbus;
  logic          w_expire;
  logic          w_owner_ack;
  logic          w_leave;

  assign w_core_req = i_ibus_cyc | i_dbus_cyc;

  // Bus mux: mirror the current owner. The fetch port has no write data.
  always_comb begin
    w_owner_cyc = 1'b0;
    w_sel_dbus  = 1'b0;
    o_wb_adr    = '0;
    o_wb_dat    = '0;
    o_wb_sel    = '0;
    o_wb_we     = 1'b0;
    case (r_state)
      CORE: begin
        w_owner_cyc = w_core_req;
        w_sel_dbus  = i_dbus_cyc;
        if (i_dbus_cyc) begin
          o_wb_adr = i_dbus_adr;
          o_wb_dat = i_dbus_dat;
          o_wb_sel = i_dbus_sel;
          o_wb_we  = i_dbus_we;
        end else begin
          o_wb_adr = i_ibus_adr;
          o_wb_sel = 4'hF;
        end
      end
      EXT: begin
        w_owner_cyc = i_ext_cyc;
        o_wb_adr    = i_ext_adr;
        o_wb_dat    = i_ext_dat;
        o_wb_sel    = i_ext_sel;
        o_wb_we     = i_ext_we;
      end
      default: ;
    endcase
  end

  assign o_wb_cyc = w_owner_cyc;

  // A real ack on the expiry cycle wins over the watchdog.
  assign w_expire    = WDOG_EN && w_owner_cyc && !i_wb_ack && (r_cnt == EXP_CNT);
  assign w_owner_ack = w_owner_cyc && (i_wb_ack || w_expire);
  // Ownership ends on completion or when the owner withdraws its cycle.
  assign w_leave     = (r_state != IDLE) && (!w_owner_cyc || w_owner_ack);

  assign o_ibus_ack = (r_state == CORE) && !w_sel_dbus && w_owner_ack;
  assign o_dbus_ack = (r_state == CORE) &&  w_sel_dbus && w_owner_ack;
  assign o_ext_ack  = (r_state == EXT)  && w_owner_ack;

  // Read data is broadcast; only the port receiving a watchdog ack sees zero.
  assign o_ibus_rdt = (w_expire && (r_state == CORE) && !w_sel_dbus) ? 32'h0 : i_wb_rdt;
  assign o_dbus_rdt = (w_expire && (r_state == CORE) &&  w_sel_dbus) ? 32'h0 : i_wb_rdt;
  assign o_ext_rdt  = (w_expire && (r_state == EXT))                 ? 32'h0 : i_wb_rdt;

  assign o_timeout = r_timeout;

  // Next-state: contention in IDLE goes to whoever did not own the bus last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_core_req && i_ext_cyc) begin
          w_state_nxt = r_last_ext ? CORE : EXT;
        end else if (w_core_req) begin
          w_state_nxt = CORE;
        end else if (i_ext_cyc) begin
          w_state_nxt = EXT;
        end
      end
      CORE, EXT: begin
        if (w_leave) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // After reset the core is treated as having waited, so it wins first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_ext <= 1'b1;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (w_leave) begin
        r_last_ext <= (r_state == EXT);
      end
      // The counter rests at zero in IDLE, so every grant starts from zero.
      if ((r_state == IDLE) || w_leave) begin
        r_cnt <= '0;
      end else if (WDOG_EN) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/serv_bus_sched.md
SERV_BUS_SCHED -- requirements
Module: serv_bus_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 8; width of the no-ack watchdog counter; 0 disables the watchdog.
REQ-002 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports i_ibus_adr / i_ibus_cyc  in  32 / 1  core instruction-fetch request (read only).
REQ-005 SHALL have ports o_ibus_rdt / o_ibus_ack  out  32 / 1  fetch data and completion strobe.
REQ-006 SHALL have ports i_dbus_adr / i_dbus_dat / i_dbus_sel / i_dbus_we / i_dbus_cyc  in  32 / 32 / 4 / 1 / 1  core data request.
REQ-007 SHALL have ports o_dbus_rdt / o_dbus_ack  out  32 / 1  core data read data and completion strobe.
REQ-008 SHALL have ports i_ext_adr / i_ext_dat / i_ext_sel / i_ext_we / i_ext_cyc  in  32 / 32 / 4 / 1 / 1  external (debug/DMA) request.
REQ-009 SHALL have ports o_ext_rdt / o_ext_ack  out  32 / 1  external read data and completion strobe.
REQ-010 SHALL have ports o_wb_adr / o_wb_dat / o_wb_sel / o_wb_we / o_wb_cyc  out  32 / 32 / 4 / 1 / 1  shared memory bus.
REQ-011 SHALL have ports i_wb_rdt / i_wb_ack  in  32 / 1  shared bus read data and ack.
REQ-012 SHALL have port o_timeout  out  1  one-cycle pulse when the watchdog aborts a transfer.

Function
REQ-013 SHALL implement FSM states IDLE, CORE, EXT plus one flag last_ext (1 = EXT was the most recent owner).
REQ-014 SHALL define core_req = i_ibus_cyc | i_dbus_cyc; within CORE, i_dbus_cyc selects the dbus bundle, else ibus.
REQ-015 In IDLE with only core_req or only i_ext_cyc, SHALL move to that owner's state next edge.
REQ-016 In IDLE with both requesting, SHALL grant CORE if last_ext=1, else EXT (strict alternation).
REQ-017 o_wb_cyc SHALL be 1 only in CORE/EXT while the owner's cyc is 1; request-to-o_wb_cyc latency = 1 cycle.
REQ-018 o_wb_adr/dat/sel/we SHALL mirror the owner; ibus owner drives we=0, sel=4'hF, dat=0; IDLE drives all zero.
REQ-019 i_wb_ack in CORE/EXT SHALL pass combinationally to exactly one owner ack (ibus, dbus or ext); ignored in IDLE.
REQ-020 On owner ack, SHALL return to IDLE next edge and set last_ext = (state==EXT); at least one IDLE cycle between grants.
REQ-021 All *_rdt SHALL equal i_wb_rdt except during a watchdog ack (REQ-023), where the owner rdt SHALL be 32'h0.
REQ-022 If the owner drops cyc before ack, SHALL return to IDLE next edge without any ack; last_ext updated as in REQ-020.
REQ-023 Watchdog: counter cleared on grant, +1 each owned cycle without i_wb_ack; at 2^TIMEOUT_W-1 SHALL assert owner ack that cycle, pulse o_timeout next cycle, go IDLE.
REQ-024 i_wb_ack coinciding with watchdog expiry SHALL be a normal completion (real rdt, no o_timeout).
REQ-025 Owner request bundle changes mid-transfer SHALL not change ownership; ibus/dbus swap within CORE follows REQ-014.

Reset
REQ-026 i_rst high SHALL immediately force state=IDLE, last_ext=1, counter=0, o_timeout=0; o_wb_cyc and all acks 0 regardless of clock.
REQ-027 Reset asserted mid-transfer SHALL drop o_wb_cyc without ack; after release, first grant follows REQ-015/016 with last_ext=1.

Verification
REQ-028 Contention: i_dbus_cyc and i_ext_cyc both 1 from reset release -> CORE first; after its ack, EXT granted after one IDLE cycle.
REQ-029 Fetch: i_ibus_cyc=1, adr=32'h100, memory acks 2 cycles after o_wb_cyc with rdt=32'h00000013 -> o_ibus_ack 1 cycle, o_ibus_rdt=32'h13, o_wb_we=0, o_wb_sel=4'hF.
REQ-030 Timeout: TIMEOUT_W=3, ext write, no i_wb_ack -> o_ext_ack on 7th owned cycle, o_ext_rdt=0, o_timeout next cycle, IDLE after.
REQ-031 Abort: ext owner drops i_ext_cyc after 2 cycles -> o_wb_cyc 0 next cycle, no o_ext_ack, pending core request granted after.
REQ-032 Async reset: assert i_rst between clock edges during CORE -> o_wb_cyc falls before next edge; stray i_wb_ack in IDLE produces no ack.
